// File: rtl/adma_pkg.sv
// Shared encodings for the ADMA2 descriptor engine: FSM states, word0 attribute
// bit positions, Act codes and error-state codes.
package adma_pkg;

  typedef enum logic [1:0] {
    ST_STOP = 2'b00,
    ST_FDS  = 2'b01,
    ST_CADR = 2'b10,
    ST_TFR  = 2'b11
  } adma_state_t;

  typedef enum logic [1:0] {
    ACT_NOP  = 2'b00,
    ACT_RSVD = 2'b01,
    ACT_TRAN = 2'b10,
    ACT_LINK = 2'b11
  } adma_act_t;

  localparam int ATTR_VALID = 0;
  localparam int ATTR_END   = 1;
  localparam int ATTR_INT   = 2;
  localparam int ACT_LSB    = 4;
  localparam int LEN_LSB    = 16;

  localparam logic [1:0] ERR_ST_STOP = 2'b00;
  localparam logic [1:0] ERR_ST_FDS  = 2'b01;
  localparam logic [1:0] ERR_ST_TFR  = 2'b11;

endpackage

// File: rtl/adma_desc_decode.sv
// Combinational split of one ADMA2 descriptor line (word0 attributes/length,
// word1 address) into its fields.
module adma_desc_decode
  import adma_pkg::*;
#(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] word0,
  input  logic [DATA_W-1:0] word1,
  output logic              desc_valid,
  output logic              desc_end,
  output logic              desc_int,
  output adma_act_t         desc_act,
  output logic [15:0]       desc_length,
  output logic [ADDR_W-1:0] desc_address
);

  assign desc_valid   = word0[ATTR_VALID];
  assign desc_end     = word0[ATTR_END];
  assign desc_int     = word0[ATTR_INT];
  assign desc_act     = adma_act_t'(word0[ACT_LSB +: 2]);
  assign desc_length  = word0[LEN_LSB +: 16];
  assign desc_address = ADDR_W'(word1);

  // Reserved attribute bits carry no meaning for this engine.
  logic unused_rsvd;
  assign unused_rsvd = ^{word0[3], word0[15:6]};

endmodule

// File: rtl/adma_descriptor_fsm.sv
// ADMA2 descriptor fetch/decode FSM driving the transfer block.
// Optional feature macro: ADMA_INT_EN (honour the descriptor Int attribute).
module adma_descriptor_fsm
  import adma_pkg::*;
#(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 32
) (
  input  logic              CLK,
  input  logic              RESET_L,
  input  logic              adma_start,
  input  logic [ADDR_W-1:0] desc_base,
  input  logic              xfer_dir,
  input  logic              stop_req,
  output logic              ram_read,
  output logic [ADDR_W-1:0] ram_address,
  input  logic [DATA_W-1:0] data_from_ram,
  output logic              ram_bus_own,
  output logic              start_transfer,
  output logic              direction,
  output logic [ADDR_W-1:0] address,
  output logic [15:0]       length,
  input  logic              TFC,
  output logic              adma_busy,
  output logic              adma_done,
  output logic              adma_error,
  output logic [1:0]        adma_err_state,
  output logic              adma_int
);

  adma_state_t       state_reg, state_next;
  logic [1:0]        fds_phase_reg, fds_phase_next;
  logic [ADDR_W-1:0] ptr_reg, ptr_next;
  logic [DATA_W-1:0] word0_reg, word0_next, word1_reg, word1_next;
  logic              stop_latch_reg, stop_latch_next;
  logic              start_reg, start_next;
  logic              direction_reg, direction_next;
  logic [ADDR_W-1:0] address_reg, address_next;
  logic [15:0]       length_reg, length_next;
  logic              done_reg, done_next, error_reg, error_next, int_reg, int_next;
  logic [1:0]        err_state_reg, err_state_next;

  logic              desc_valid, desc_end, desc_int;
  adma_act_t         desc_act;
  logic [15:0]       desc_length;
  logic [ADDR_W-1:0] desc_address;
  logic              complete;
  logic [ADDR_W-1:0] complete_ptr;

  adma_desc_decode #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_decode (
    .word0        (word0_reg),
    .word1        (word1_reg),
    .desc_valid   (desc_valid),
    .desc_end     (desc_end),
    .desc_int     (desc_int),
    .desc_act     (desc_act),
    .desc_length  (desc_length),
    .desc_address (desc_address)
  );

`ifndef ADMA_INT_EN
  logic unused_int;
  assign unused_int = desc_int;
`endif

  always_ff @(posedge CLK or negedge RESET_L) begin
    if (!RESET_L) begin
      state_reg      <= ST_STOP;
      fds_phase_reg  <= 2'd0;
      ptr_reg        <= '0;
      word0_reg      <= '0;
      word1_reg      <= '0;
      stop_latch_reg <= 1'b0;
      start_reg      <= 1'b0;
      direction_reg  <= 1'b0;
      address_reg    <= '0;
      length_reg     <= '0;
      done_reg       <= 1'b0;
      error_reg      <= 1'b0;
      int_reg        <= 1'b0;
      err_state_reg  <= ERR_ST_STOP;
    end else begin
      state_reg      <= state_next;
      fds_phase_reg  <= fds_phase_next;
      ptr_reg        <= ptr_next;
      word0_reg      <= word0_next;
      word1_reg      <= word1_next;
      stop_latch_reg <= stop_latch_next;
      start_reg      <= start_next;
      direction_reg  <= direction_next;
      address_reg    <= address_next;
      length_reg     <= length_next;
      done_reg       <= done_next;
      error_reg      <= error_next;
      int_reg        <= int_next;
      err_state_reg  <= err_state_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    fds_phase_next  = fds_phase_reg;
    ptr_next        = ptr_reg;
    word0_next      = word0_reg;
    word1_next      = word1_reg;
    stop_latch_next = stop_latch_reg | stop_req;
    start_next      = 1'b0;
    direction_next  = direction_reg;
    address_next    = address_reg;
    length_next     = length_reg;
    done_next       = 1'b0;
    error_next      = 1'b0;
    int_next        = 1'b0;
    err_state_next  = err_state_reg;
    complete        = 1'b0;
    complete_ptr    = ptr_reg + ADDR_W'(2);

    case (state_reg)
      ST_STOP: begin
        if (adma_start) begin
          ptr_next        = desc_base;
          stop_latch_next = 1'b0;
          err_state_next  = ERR_ST_STOP;
          fds_phase_next  = 2'd0;
          state_next      = ST_FDS;
        end
      end
      ST_FDS: begin
        // Read data lags the strobe by one cycle, so each word lands one phase later.
        case (fds_phase_reg)
          2'd0: fds_phase_next = 2'd1;
          2'd1: begin
            word0_next     = data_from_ram;
            fds_phase_next = 2'd2;
          end
          default: begin
            word1_next     = data_from_ram;
            fds_phase_next = 2'd0;
            state_next     = ST_CADR;
          end
        endcase
      end
      ST_CADR: begin
        if (!desc_valid) begin
          error_next     = 1'b1;
          err_state_next = ERR_ST_FDS;
          state_next     = ST_STOP;
        end else if (desc_act == ACT_TRAN && desc_length != 16'd0) begin
          address_next   = desc_address;
          length_next    = desc_length;
          direction_next = xfer_dir;
          start_next     = 1'b1;
          state_next     = ST_TFR;
        end else begin
          complete = 1'b1;
          if (desc_act == ACT_LINK) complete_ptr = desc_address;
        end
      end
      ST_TFR: begin
        if (TFC) complete = 1'b1;
      end
      default: state_next = ST_STOP;
    endcase

    if (complete) begin
      ptr_next = complete_ptr;
`ifdef ADMA_INT_EN
      int_next = desc_int;
`endif
      if (desc_end) begin
        done_next  = 1'b1;
        state_next = ST_STOP;
      end else if (stop_latch_reg || stop_req) begin
        state_next = ST_STOP;
      end else begin
        fds_phase_next = 2'd0;
        state_next     = ST_FDS;
      end
    end
  end

  assign ram_bus_own    = (state_reg == ST_FDS);
  assign ram_read       = ram_bus_own && (fds_phase_reg != 2'd2);
  assign ram_address    = !ram_bus_own ? '0 :
                          (fds_phase_reg == 2'd0) ? ptr_reg : ptr_reg + ADDR_W'(1);
  assign start_transfer = start_reg;
  assign direction      = direction_reg;
  assign address        = address_reg;
  assign length         = length_reg;
  assign adma_busy      = (state_reg != ST_STOP);
  assign adma_done      = done_reg;
  assign adma_error     = error_reg;
  assign adma_err_state = err_state_reg;
  assign adma_int       = int_reg;

endmodule

// File: tb/tb_adma_descriptor_fsm.sv
// Scoreboard bench for adma_descriptor_fsm: expected RAM reads and transfer
// issues are queued per scenario and checked as the DUT produces them.
module tb_adma_descriptor_fsm;

  logic        CLK = 1'b0;
  logic        RESET_L = 1'b0;
  logic        adma_start = 1'b0;
  logic [63:0] desc_base = '0;
  logic        xfer_dir = 1'b0;
  logic        stop_req = 1'b0;
  logic        ram_read;
  logic [63:0] ram_address;
  logic [31:0] data_from_ram = '0;
  logic        ram_bus_own;
  logic        start_transfer;
  logic        direction;
  logic [63:0] address;
  logic [15:0] length;
  logic        TFC = 1'b0;
  logic        adma_busy, adma_done, adma_error, adma_int;
  logic [1:0]  adma_err_state;

  adma_descriptor_fsm dut (
    .CLK(CLK), .RESET_L(RESET_L), .adma_start(adma_start), .desc_base(desc_base),
    .xfer_dir(xfer_dir), .stop_req(stop_req), .ram_read(ram_read),
    .ram_address(ram_address), .data_from_ram(data_from_ram), .ram_bus_own(ram_bus_own),
    .start_transfer(start_transfer), .direction(direction), .address(address),
    .length(length), .TFC(TFC), .adma_busy(adma_busy), .adma_done(adma_done),
    .adma_error(adma_error), .adma_err_state(adma_err_state), .adma_int(adma_int)
  );

  always #5 CLK = ~CLK;

  logic [31:0] mem [logic [63:0]];
  always @(posedge CLK)
    if (ram_read) data_from_ram <= mem.exists(ram_address) ? mem[ram_address] : 32'h0;

  typedef struct {
    logic [63:0] addr;
    logic [15:0] len;
    logic        dir;
  } xfer_t;

  logic [63:0] exp_reads[$];
  xfer_t       exp_xfers[$];
  int vectors = 0;
  int miscompares = 0;
  int cycle = 0;
  int start_cyc = 0;
  int xfer_count = 0;

`ifdef ADMA_INT_EN
  localparam logic EXP_INT = 1'b1;
`else
  localparam logic EXP_INT = 1'b0;
`endif

  // Advance one clock and score any read strobe or transfer issue in that cycle.
  task automatic tick();
    logic [63:0] ea;
    xfer_t ex;
    @(posedge CLK);
    #1;
    cycle++;
    if (ram_read) begin
      vectors++;
      if (exp_reads.size() == 0) begin
        miscompares++;
        $display("FAIL ram_read: unexpected read at 0x%0h, required no read", ram_address);
      end else begin
        ea = exp_reads.pop_front();
        if (ram_address !== ea || ram_bus_own !== 1'b1) begin
          miscompares++;
          $display("FAIL ram_read: addr=0x%0h own=%0b, required addr=0x%0h own=1",
                   ram_address, ram_bus_own, ea);
        end else
          $display("cyc %0d read addr=0x%0h", cycle, ram_address);
      end
    end
    if (start_transfer) begin
      vectors++;
      xfer_count++;
      if (exp_xfers.size() == 0) begin
        miscompares++;
        $display("FAIL start_transfer: unexpected issue addr=0x%0h len=%0d", address, length);
      end else begin
        ex = exp_xfers.pop_front();
        if (address !== ex.addr || length !== ex.len || direction !== ex.dir) begin
          miscompares++;
          $display("FAIL start_transfer: addr=0x%0h len=%0d dir=%0b, required addr=0x%0h len=%0d dir=%0b",
                   address, length, direction, ex.addr, ex.len, ex.dir);
        end else
          $display("cyc %0d transfer addr=0x%0h len=%0d dir=%0b", cycle, address, length, direction);
      end
    end
  endtask

  task automatic start_engine(input logic [63:0] base);
    desc_base  = base;
    adma_start = 1'b1;
    start_cyc  = cycle;
    tick();
    adma_start = 1'b0;
    desc_base  = 64'h0;
  endtask

  // which: 0 = start_transfer, 1 = adma_done, 2 = adma_error
  task automatic wait_for(input int which, input int budget, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      tick();
      case (which)
        0: seen = start_transfer;
        1: seen = adma_done;
        default: seen = adma_error;
      endcase
    end
  endtask

  task automatic pulse_tfc();
    TFC = 1'b1;
    tick();
    TFC = 1'b0;
  endtask

  task automatic test_reset();
    RESET_L = 1'b0;
    repeat (3) tick();
    vectors++;
    if ({ram_read, ram_bus_own, start_transfer, direction, adma_busy, adma_done,
         adma_error, adma_int} !== 8'h0 || ram_address !== 64'h0 || address !== 64'h0 ||
        length !== 16'h0 || adma_err_state !== 2'b00) begin
      miscompares++;
      $display("FAIL reset: busy=%0b read=%0b addr=0x%0h err_state=%0b, required all zero",
               adma_busy, ram_read, ram_address, adma_err_state);
    end else
      $display("cyc %0d reset outputs zero", cycle);
    RESET_L = 1'b1;
    tick();
  endtask

  task automatic test_single();
    bit seen;
    mem[64'h20] = 32'h0010_0023;
    mem[64'h21] = 32'h0000_0100;
    exp_reads.push_back(64'h20);
    exp_reads.push_back(64'h21);
    exp_xfers.push_back('{addr: 64'h100, len: 16'd16, dir: 1'b1});
    xfer_dir = 1'b1;
    start_engine(64'h20);
    vectors++;
    if (ram_read !== 1'b1 || ram_address !== 64'h20 || adma_busy !== 1'b1) begin
      miscompares++;
      $display("FAIL single_t1: read=%0b addr=0x%0h busy=%0b, required 1/0x20/1",
               ram_read, ram_address, adma_busy);
    end
    wait_for(0, 10, seen);
    vectors++;
    if (!seen || cycle - start_cyc != 5) begin
      miscompares++;
      $display("FAIL single_latency: seen=%0b at t+%0d, required t+5", seen, cycle - start_cyc);
    end
    xfer_dir = 1'b0;
    tick();
    tick();
    vectors++;
    if (start_transfer !== 1'b0 || adma_busy !== 1'b1 || direction !== 1'b1 ||
        address !== 64'h100 || length !== 16'd16) begin
      miscompares++;
      $display("FAIL single_hold: st=%0b busy=%0b dir=%0b addr=0x%0h len=%0d, required 0/1/1/0x100/16",
               start_transfer, adma_busy, direction, address, length);
    end
    pulse_tfc();
    vectors++;
    if (adma_done !== 1'b1 || adma_busy !== 1'b0 || adma_int !== 1'b0) begin
      miscompares++;
      $display("FAIL single_done: done=%0b busy=%0b int=%0b, required 1/0/0",
               adma_done, adma_busy, adma_int);
    end else
      $display("cyc %0d done", cycle);
    tick();
    vectors++;
    if (adma_done !== 1'b0) begin
      miscompares++;
      $display("FAIL single_done_pulse: done=%0b, required 0", adma_done);
    end
  endtask

  task automatic test_chain();
    bit seen;
    int x0;
    mem[64'h20] = 32'h0000_0001;
    mem[64'h21] = 32'hDEAD_BEEF;
    mem[64'h22] = 32'h0000_0031;
    mem[64'h23] = 32'h0000_0080;
    mem[64'h80] = 32'h0008_0023;
    mem[64'h81] = 32'h0000_0200;
    foreach (mem[a]) if (a == 64'h20 || a == 64'h21 || a == 64'h22 || a == 64'h23) exp_reads.push_back(a);
    exp_reads.push_back(64'h80);
    exp_reads.push_back(64'h81);
    exp_xfers.push_back('{addr: 64'h200, len: 16'd8, dir: 1'b1});
    xfer_dir = 1'b1;
    x0 = xfer_count;
    start_engine(64'h20);
    pulse_tfc();
    wait_for(0, 20, seen);
    vectors++;
    if (!seen) begin
      miscompares++;
      $display("FAIL chain_issue: no start_transfer within budget");
    end
    pulse_tfc();
    vectors++;
    if (adma_done !== 1'b1 || xfer_count - x0 != 1 || exp_reads.size() != 0) begin
      miscompares++;
      $display("FAIL chain_done: done=%0b issues=%0d reads_left=%0d, required 1/1/0",
               adma_done, xfer_count - x0, exp_reads.size());
    end else
      $display("cyc %0d chain done", cycle);
  endtask

  task automatic test_invalid();
    bit seen;
    int x0;
    mem[64'h20] = 32'h0010_0020;
    mem[64'h21] = 32'h0000_0100;
    exp_reads.push_back(64'h20);
    exp_reads.push_back(64'h21);
    x0 = xfer_count;
    start_engine(64'h20);
    wait_for(2, 10, seen);
    vectors++;
    if (!seen || cycle - start_cyc != 5 || adma_err_state !== 2'b01 || adma_busy !== 1'b0 ||
        xfer_count != x0) begin
      miscompares++;
      $display("FAIL invalid: seen=%0b t+%0d err_state=%0b busy=%0b issues=%0d, required 1/t+5/01/0/0",
               seen, cycle - start_cyc, adma_err_state, adma_busy, xfer_count - x0);
    end else
      $display("cyc %0d error err_state=%0b", cycle, adma_err_state);
    tick();
    vectors++;
    if (adma_error !== 1'b0 || adma_err_state !== 2'b01) begin
      miscompares++;
      $display("FAIL invalid_hold: error=%0b err_state=%0b, required 0/01", adma_error, adma_err_state);
    end
  endtask

  task automatic test_stop();
    bit seen;
    mem[64'h20] = 32'h0004_0021;
    mem[64'h21] = 32'h0000_0300;
    mem[64'h22] = 32'h0004_0023;
    mem[64'h23] = 32'h0000_0400;
    exp_reads.push_back(64'h20);
    exp_reads.push_back(64'h21);
    exp_xfers.push_back('{addr: 64'h300, len: 16'd4, dir: 1'b0});
    xfer_dir = 1'b0;
    start_engine(64'h20);
    vectors++;
    if (adma_err_state !== 2'b00) begin
      miscompares++;
      $display("FAIL stop_errclr: err_state=%0b, required 00", adma_err_state);
    end
    wait_for(0, 10, seen);
    stop_req = 1'b1;
    tick();
    stop_req   = 1'b0;
    adma_start = 1'b1;
    desc_base  = 64'h999;
    tick();
    adma_start = 1'b0;
    tick();
    vectors++;
    if (!seen || adma_busy !== 1'b1 || ram_read !== 1'b0) begin
      miscompares++;
      $display("FAIL stop_tfr: seen=%0b busy=%0b read=%0b, required 1/1/0", seen, adma_busy, ram_read);
    end
    pulse_tfc();
    vectors++;
    if (adma_busy !== 1'b0 || adma_done !== 1'b0) begin
      miscompares++;
      $display("FAIL stop_end: busy=%0b done=%0b, required 0/0", adma_busy, adma_done);
    end else
      $display("cyc %0d stopped at boundary", cycle);
    repeat (4) tick();
  endtask

  task automatic test_int();
    bit seen;
    mem[64'h40] = 32'h0002_0027;
    mem[64'h41] = 32'h0000_0500;
    exp_reads.push_back(64'h40);
    exp_reads.push_back(64'h41);
    exp_xfers.push_back('{addr: 64'h500, len: 16'd2, dir: 1'b1});
    xfer_dir = 1'b1;
    start_engine(64'h40);
    wait_for(0, 10, seen);
    tick();
    pulse_tfc();
    vectors++;
    if (!seen || adma_int !== EXP_INT || adma_done !== 1'b1) begin
      miscompares++;
      $display("FAIL int: seen=%0b int=%0b done=%0b, required 1/%0b/1", seen, adma_int, adma_done, EXP_INT);
    end else
      $display("cyc %0d int=%0b done", cycle, adma_int);
    tick();
    vectors++;
    if (adma_int !== 1'b0) begin
      miscompares++;
      $display("FAIL int_pulse: int=%0b, required 0", adma_int);
    end
  endtask

  task automatic test_reset_mid();
    bit seen;
    mem[64'h60] = 32'h0006_0023;
    mem[64'h61] = 32'h0000_0600;
    for (int r = 0; r < 2; r++) begin
      exp_reads.push_back(64'h60);
      exp_reads.push_back(64'h61);
      exp_xfers.push_back('{addr: 64'h600, len: 16'd6, dir: 1'b1});
    end
    xfer_dir = 1'b1;
    start_engine(64'h60);
    wait_for(0, 10, seen);
    tick();
    #2 RESET_L = 1'b0;
    #1;
    vectors++;
    if (!seen || adma_busy !== 1'b0 || address !== 64'h0 || length !== 16'h0 ||
        direction !== 1'b0 || ram_bus_own !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid: seen=%0b busy=%0b addr=0x%0h len=%0d, required 1/0/0/0",
               seen, adma_busy, address, length);
    end else
      $display("cyc %0d async reset cleared outputs", cycle);
    tick();
    RESET_L = 1'b1;
    tick();
    start_engine(64'h60);
    wait_for(0, 10, seen);
    pulse_tfc();
    vectors++;
    if (!seen || adma_done !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_restart: seen=%0b done=%0b, required 1/1", seen, adma_done);
    end else
      $display("cyc %0d restart done", cycle);
  endtask

  initial begin
    test_reset();
    test_single();
    test_chain();
    test_invalid();
    test_stop();
    test_int();
    test_reset_mid();
    repeat (3) tick();
    vectors++;
    if (exp_reads.size() != 0 || exp_xfers.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: reads_left=%0d xfers_left=%0d, required 0/0",
               exp_reads.size(), exp_xfers.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
